// File: rtl/adc_resp_model_pkg.sv
// Shared types and constants for the ADC responder model (package adc_simu_pkg).
package adc_simu_pkg;

  localparam int ADC_DATA_W = 12;
  localparam int ADC_CH_W   = 5;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 mapped onto bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    RESPOND
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  // Per-channel ramp increment STEP*(ch+1), formed at 17 bits then cut to 12.
  function automatic logic [ADC_DATA_W-1:0] ramp_inc(input logic [ADC_CH_W-1:0] ch,
                                                     input int unsigned        step);
    logic [16:0] prod;
    prod = 17'(step) * (17'(ch) + 17'd1);
    return prod[ADC_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/adc_resp_model_if.sv
// Command/response Avalon-ST bundle between an ADC sequencer and the responder.
interface adc_resp_model_if;
  import adc_simu_pkg::*;

  logic                  command_valid;
  logic [ADC_CH_W-1:0]   command_channel;
  logic                  command_startofpacket;
  logic                  command_endofpacket;
  logic                  command_ready;
  logic                  response_valid;
  logic [ADC_CH_W-1:0]   response_channel;
  logic [ADC_DATA_W-1:0] response_data;
  logic                  response_startofpacket;
  logic                  response_endofpacket;
  logic [15:0]           sample_count;

  modport master (
    output command_valid, command_channel, command_startofpacket, command_endofpacket,
    input  command_ready, response_valid, response_channel, response_data,
           response_startofpacket, response_endofpacket, sample_count
  );

  modport slave (
    input  command_valid, command_channel, command_startofpacket, command_endofpacket,
    output command_ready, response_valid, response_channel, response_data,
           response_startofpacket, response_endofpacket, sample_count
  );
endinterface

// File: rtl/adc_resp_model_ramp_bank.sv
// Bank of per-channel 12-bit ramp registers with a read mux and an add-in-place update.
// Channels outside 0..NUM_CH-1 read as zero and are never written.
module adc_ramp_bank
  import adc_simu_pkg::*;
#(
  parameter int NUM_CH = 8
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [ADC_CH_W-1:0]   rd_ch_i,
  output logic [ADC_DATA_W-1:0] rd_data_o,
  input  logic                  upd_en_i,
  input  logic [ADC_CH_W-1:0]   upd_ch_i,
  input  logic [ADC_DATA_W-1:0] upd_inc_i
);

  logic [ADC_DATA_W-1:0] ramp_q [NUM_CH];

  // Read mux; unmatched channel returns zero.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch_i == ADC_CH_W'(i)) rd_data_o = ramp_q[i];
    end
  end

  // Ramp update, wrapping modulo 4096.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_CH; i++) ramp_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (upd_en_i && (upd_ch_i == ADC_CH_W'(i))) ramp_q[i] <= ramp_q[i] + upd_inc_i;
      end
    end
  end

endmodule

// File: rtl/adc_resp_model.sv
// ADC command/response responder model: one 12-bit ramp sample per accepted command.
// Optional feature macro: ADC_RESP_NOISE_EN adds LFSR noise (-4..+3, clamped) to samples.
//
// state   | meaning
// IDLE    | command_ready high, waiting for a command
// CONVERT | conversion latency countdown, commands blocked
// RESPOND | read/update ramp, launch the one-beat response
module adc_resp_model
  import adc_simu_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CONV_CYCLES = 4,
  parameter int STEP        = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  adc_resp_model_if.slave   bus
);

  localparam int              CNT_W    = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADC_CH_W-1:0]   ch_q, ch_d;
  logic                  rsp_valid_q;
  logic [ADC_CH_W-1:0]   rsp_ch_q;
  logic [ADC_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [15:0]           count_q;
  logic [ADC_DATA_W-1:0] ramp_val;
  logic                  accept;
  logic                  respond;
  logic                  unused_pkt;

  // Packet markers on the command side carry no information for single-beat commands.
  assign unused_pkt = bus.command_startofpacket ^ bus.command_endofpacket;

  assign bus.command_ready = (state_q == IDLE) && reset_reset_n;
  assign accept            = bus.command_valid && bus.command_ready;
  assign respond           = (state_q == RESPOND);

  // Next-state, counter and channel-latch logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ch_d    = bus.command_channel;
          cnt_d   = CNT_LOAD;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (cnt_q == '0) state_d = RESPOND;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, conversion counter and latched channel.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
    end
  end

  adc_ramp_bank #(.NUM_CH(NUM_CH)) u_ramp_bank (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .rd_ch_i       (ch_q),
    .rd_data_o     (ramp_val),
    .upd_en_i      (respond),
    .upd_ch_i      (ch_q),
    .upd_inc_i     (ramp_inc(ch_q, STEP))
  );

`ifdef ADC_RESP_NOISE_EN
  logic [15:0]                  lfsr_q;
  logic                         ch_valid;
  logic signed [ADC_DATA_W+1:0] noisy;

  assign ch_valid = (ch_q < ADC_CH_W'(NUM_CH));

  // Noise source steps once per response, valid channel or not.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) lfsr_q <= LFSR_SEED;
    else if (respond)   lfsr_q <= lfsr_next(lfsr_q);
  end

  // Add signed 3-bit noise and clamp; invalid channels stay at zero.
  always_comb begin
    noisy = $signed({2'b00, ramp_val}) + $signed({{11{lfsr_q[2]}}, lfsr_q[2:0]});
    if (!ch_valid)                rsp_data_d = '0;
    else if (noisy < 0)           rsp_data_d = '0;
    else if (noisy > 14'sd4095)   rsp_data_d = 12'hFFF;
    else                          rsp_data_d = noisy[ADC_DATA_W-1:0];
  end
`else
  assign rsp_data_d = ramp_val;
`endif

  // Registered response beat and sample counter.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_ch_q    <= '0;
      rsp_data_q  <= '0;
      count_q     <= '0;
    end else begin
      rsp_valid_q <= respond;
      if (respond) begin
        rsp_ch_q   <= ch_q;
        rsp_data_q <= rsp_data_d;
        count_q    <= count_q + 16'd1;
      end
    end
  end

  assign bus.response_valid         = rsp_valid_q;
  assign bus.response_channel       = rsp_ch_q;
  assign bus.response_data          = rsp_data_q;
  assign bus.response_startofpacket = rsp_valid_q;
  assign bus.response_endofpacket   = rsp_valid_q;
  assign bus.sample_count           = count_q;

endmodule

// File: tb/tb_adc_resp_model.sv
// Directed bench for adc_resp_model with default parameters (8 channels, 4-cycle conversion, step 16).
module tb_adc_resp_model;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  adc_resp_model_if bus();

  adc_resp_model #(.NUM_CH(8), .CONV_CYCLES(4), .STEP(16)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ch;
    logic [11:0] data;
    logic [15:0] count;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.command_valid   = 1'b1;
    bus.command_channel = 5'd0;
    repeat (2) @(negedge clk);
    bus.command_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  // Issue one command and wait for its response; lat is cycles from accept edge, 99 on timeout.
  task automatic do_cmd(input logic [4:0] ch, output logic [11:0] d, output logic [4:0] rc,
                        output logic [15:0] sc, output int lat);
    int  n;
    bit  seen;
    @(negedge clk);
    bus.command_channel = ch;
    bus.command_valid   = 1'b1;
    n = 0;
    while (!bus.command_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    @(posedge clk);
    #1;
    bus.command_valid   = 1'b0;
    bus.command_channel = ~ch;
    lat  = 0;
    seen = 1'b0;
    d = '0; rc = '0; sc = '0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.response_valid) begin
        seen = 1'b1;
        d  = bus.response_data;
        rc = bus.response_channel;
        sc = bus.sample_count;
      end
    end
    if (!seen) lat = 99;
  endtask

  initial begin
    logic [11:0] d;
    logic [4:0]  rc;
    logic [15:0] sc;
    int          lat;
    int          nresp;
    int          prev_c;
    bit          seen;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.command_valid         = 1'b0;
    bus.command_channel       = '0;
    bus.command_startofpacket = 1'b1;
    bus.command_endofpacket   = 1'b1;

    vecs[0]  = '{5'd1,  12'd32,  16'd2};
    vecs[1]  = '{5'd3,  12'd0,   16'd3};
    vecs[2]  = '{5'd3,  12'd64,  16'd4};
    vecs[3]  = '{5'd9,  12'd0,   16'd5};
    vecs[4]  = '{5'd0,  12'd0,   16'd6};
    vecs[5]  = '{5'd0,  12'd16,  16'd7};
    vecs[6]  = '{5'd31, 12'd0,   16'd8};
    vecs[7]  = '{5'd7,  12'd0,   16'd9};
    vecs[8]  = '{5'd1,  12'd64,  16'd10};
    vecs[9]  = '{5'd8,  12'd0,   16'd11};
    vecs[10] = '{5'd7,  12'd128, 16'd12};

    // Reset with a pending command request.
    @(negedge clk);
    bus.command_valid   = 1'b1;
    bus.command_channel = 5'd2;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.command_ready, 0);
    chk("rst_valid", bus.response_valid, 0);
    chk("rst_data",  bus.response_data, 0);
    chk("rst_chan",  bus.response_channel, 0);
    chk("rst_sop",   bus.response_startofpacket, 0);
    chk("rst_eop",   bus.response_endofpacket, 0);
    chk("rst_count", bus.sample_count, 0);
    bus.command_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", bus.command_ready, 1);

    // Single ch1 command: response_valid exactly at accept+5.
    @(negedge clk);
    bus.command_valid   = 1'b1;
    bus.command_channel = 5'd1;
    @(posedge clk);
    #1;
    bus.command_valid   = 1'b0;
    bus.command_channel = 5'd4;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("lat_valid_k%0d", k), bus.response_valid, (k == 5) ? 1 : 0);
      if (k == 5) begin
        chk("single_chan",  bus.response_channel, 1);
        chk("single_data",  bus.response_data, 0);
        chk("single_sop",   bus.response_startofpacket, 1);
        chk("single_eop",   bus.response_endofpacket, 1);
        chk("single_count", bus.sample_count, 1);
      end
    end

    // Table of single commands continuing from the state above.
    for (int i = 0; i < 11; i++) begin
      do_cmd(vecs[i].ch, d, rc, sc, lat);
      chk($sformatf("vec%0d_lat", i),   lat, 5);
      chk($sformatf("vec%0d_chan", i),  rc, vecs[i].ch);
      chk($sformatf("vec%0d_data", i),  d, vecs[i].data);
      chk($sformatf("vec%0d_count", i), sc, vecs[i].count);
    end

    // Held command_valid on ch3: one response every 6 cycles.
    do_reset();
    @(negedge clk);
    bus.command_valid   = 1'b1;
    bus.command_channel = 5'd3;
    nresp  = 0;
    prev_c = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (bus.response_valid) begin
        chk($sformatf("held_data%0d", nresp),  bus.response_data, 32'(64 * nresp));
        chk($sformatf("held_count%0d", nresp), bus.sample_count, 32'(nresp + 1));
        if (nresp > 0) chk($sformatf("held_gap%0d", nresp), c - prev_c, 6);
        prev_c = c;
        nresp++;
      end
    end
    bus.command_valid = 1'b0;
    chk("held_nresp", nresp, 5);

    // ch7 repeated 33 times: steps of 128, wrapping to 0 on the 33rd.
    do_reset();
    for (int i = 0; i < 33; i++) begin
      do_cmd(5'd7, d, rc, sc, lat);
      chk($sformatf("ch7_data%0d", i), d, (i == 32) ? 0 : 128 * i);
    end
    chk("ch7_lat_last", lat, 5);

    // Reset pulse during CONVERT drops the response and clears ramps.
    do_reset();
    do_cmd(5'd0, d, rc, sc, lat);
    chk("pre_ch0_a", d, 0);
    do_cmd(5'd0, d, rc, sc, lat);
    chk("pre_ch0_b", d, 16);
    @(negedge clk);
    bus.command_valid   = 1'b1;
    bus.command_channel = 5'd0;
    @(posedge clk);
    #1;
    bus.command_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("conv_rst_ready", bus.command_ready, 1);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.response_valid) seen = 1'b1;
    end
    chk("conv_rst_no_resp", seen, 0);
    chk("conv_rst_count", bus.sample_count, 0);
    do_cmd(5'd0, d, rc, sc, lat);
    chk("post_rst_data",  d, 0);
    chk("post_rst_count", sc, 1);
    chk("post_rst_lat",   lat, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
